// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the round-robin stream multiplexer.
package stream_mux_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam logic MODE_STATIC = 1'b0;
   localparam logic MODE_RR     = 1'b1;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] gnt
);

   logic [NUM_CH-1:0] req_rot_s;
   logic [NUM_CH-1:0] gnt_rot_s;

   // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
   always_comb begin
      req_rot_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         req_rot_s[i] = req[(i + int'(ptr)) % NUM_CH];
      end
      gnt_rot_s = req_rot_s & (~req_rot_s + {{(NUM_CH-1){1'b0}}, 1'b1});
      gnt = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         gnt[(i + int'(ptr)) % NUM_CH] = gnt_rot_s[i];
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream mux with static or round-robin selection,
// packet lock until in_last, and a single registered output stage.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 8,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [CH_W-1:0]         sel,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH-1:0]       in_last,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   output logic                    out_last,
   output logic [CH_W-1:0]         out_ch,
   input  logic                    out_ready
);

   state_e            state_r, state_nxt_s;
   logic [CH_W-1:0]   lock_ch_r, lock_ch_nxt_s;
   logic              lock_rr_r, lock_rr_nxt_s;
   logic [CH_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
   logic [NUM_CH-1:0] rr_gnt_s, grant_s;
   logic              can_load_s, accept_s;
   logic [CH_W-1:0]   acc_ch_s, rr_inc_s;
   logic [WIDTH-1:0]  acc_data_s;
   logic              acc_last_s;
   logic [WIDTH-1:0]  out_data_r;
   logic              out_valid_r, out_last_r;
   logic [CH_W-1:0]   out_ch_r;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req (in_valid),
      .ptr (rr_ptr_r),
      .gnt (rr_gnt_s)
   );

   // Grant selection: mode/sel only matter in IDLE, LOCKED follows lock_ch.
   always_comb begin
      grant_s = {NUM_CH{1'b0}};
      case (state_r)
         IDLE: begin
            if (mode == MODE_RR) begin
               grant_s = rr_gnt_s;
            end else if (int'(sel) < NUM_CH) begin
               grant_s[sel] = in_valid[sel];
            end else begin
               grant_s = {NUM_CH{1'b0}};
            end
         end
         LOCKED:  grant_s[lock_ch_r] = in_valid[lock_ch_r];
         default: grant_s = {NUM_CH{1'b0}};
      endcase
   end

   // Input handshake and the payload of the granted channel.
   always_comb begin
      can_load_s = ~out_valid_r | out_ready;
      if (rst_n) begin
         in_ready = grant_s & {NUM_CH{can_load_s}};
      end else begin
         in_ready = {NUM_CH{1'b0}};
      end
      accept_s = |(in_valid & in_ready);
      acc_ch_s = {CH_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         acc_ch_s = acc_ch_s | (grant_s[i] ? CH_W'(i) : {CH_W{1'b0}});
      end
      acc_data_s = in_data[acc_ch_s*WIDTH +: WIDTH];
      acc_last_s = in_last[acc_ch_s];
      rr_inc_s   = (acc_ch_s == CH_W'(NUM_CH-1)) ? {CH_W{1'b0}} : acc_ch_s + CH_W'(1);
   end

   // Packet-lock FSM; the lock remembers whether it began in round-robin mode
   // so a mode toggle mid-packet cannot change how rr_ptr advances.
   always_comb begin
      state_nxt_s   = state_r;
      lock_ch_nxt_s = lock_ch_r;
      lock_rr_nxt_s = lock_rr_r;
      rr_ptr_nxt_s  = rr_ptr_r;
      case (state_r)
         IDLE: begin
            if (accept_s && !acc_last_s) begin
               state_nxt_s   = LOCKED;
               lock_ch_nxt_s = acc_ch_s;
               lock_rr_nxt_s = (mode == MODE_RR);
            end else if (accept_s && (mode == MODE_RR)) begin
               rr_ptr_nxt_s = rr_inc_s;
            end else begin
               rr_ptr_nxt_s = rr_ptr_r;
            end
         end
         LOCKED: begin
            if (accept_s && acc_last_s) begin
               state_nxt_s  = IDLE;
               rr_ptr_nxt_s = lock_rr_r ? rr_inc_s : rr_ptr_r;
            end else begin
               state_nxt_s = LOCKED;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, pointer and output register; a load may coincide with a drain.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         lock_ch_r   <= {CH_W{1'b0}};
         lock_rr_r   <= 1'b0;
         rr_ptr_r    <= {CH_W{1'b0}};
         out_data_r  <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_ch_r    <= {CH_W{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         lock_ch_r <= lock_ch_nxt_s;
         lock_rr_r <= lock_rr_nxt_s;
         rr_ptr_r  <= rr_ptr_nxt_s;
         if (accept_s) begin
            out_data_r  <= acc_data_s;
            out_valid_r <= 1'b1;
            out_last_r  <= acc_last_s;
            out_ch_r    <= acc_ch_s;
         end else if (out_ready) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign out_data  = out_data_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: directed stimulus pushes expected beats,
// a negedge monitor pops and compares every output transfer.
module tb_stream_mux_rr;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic [1:0] ch;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid, in_last, in_ready;
   logic [7:0]  out_data;
   logic        out_valid, out_last, out_ready;
   logic [1:0]  out_ch;

   logic        mode8;
   logic [2:0]  sel8;
   logic [63:0] in_data8;
   logic [7:0]  in_valid8, in_last8, in_ready8;
   logic [7:0]  out_data8;
   logic        out_valid8, out_last8, out_ready8;
   logic [2:0]  out_ch8;

   beat_t exp_q[$];
   beat_t mon_exp;
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
      .out_ch(out_ch), .out_ready(out_ready)
   );

   stream_mux_rr #(.NUM_CH(8), .WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8),
      .in_data(in_data8), .in_valid(in_valid8), .in_last(in_last8), .in_ready(in_ready8),
      .out_data(out_data8), .out_valid(out_valid8), .out_last(out_last8),
      .out_ch(out_ch8), .out_ready(out_ready8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic l, input logic [1:0] c);
      beat_t b;
      b.data = d;
      b.last = l;
      b.ch   = c;
      exp_q.push_back(b);
   endtask

   // Monitor: every output transfer must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got ch %0d data %0h expected no beat", out_ch, out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            chk("out_beat", {53'd0, out_data, out_last, out_ch}, {53'd0, mon_exp});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      out_ready = 1'b1;
      mode8      = 1'b0;
      sel8       = 3'd5;
      in_valid8  = 8'h0F;
      in_last8   = 8'hFF;
      in_data8   = {32'h0, 8'h33, 8'h22, 8'h11, 8'h00};
      out_ready8 = 1'b1;

      // Reset with all channels valid
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {60'd0, in_ready}, 64'd0);
      chk("rst_out_ch", {62'd0, out_ch}, 64'd0);
      chk("rst_out_data", {56'd0, out_data}, 64'd0);

      // Round-robin fairness, single-beat packets
      rst_n = 1'b1;
      @(negedge clk);
      chk("rr_first_grant", {60'd0, in_ready}, 64'h1);
      push(8'hA0, 1'b1, 2'd0);
      push(8'hA1, 1'b1, 2'd1);
      push(8'hA2, 1'b1, 2'd2);
      push(8'hA3, 1'b1, 2'd3);
      push(8'hA0, 1'b1, 2'd0);
      push(8'hA1, 1'b1, 2'd1);
      for (int i = 0; i < 6; i++) tick();
      in_valid = 4'b0000;
      tick();

      // Static select of ch2
      mode     = 1'b0;
      sel      = 2'd2;
      in_valid = 4'b1111;
      in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
      @(negedge clk);
      chk("static_ready", {60'd0, in_ready}, 64'h4);
      push(8'hA5, 1'b1, 2'd2);
      tick();
      in_valid = 4'b0000;
      tick();

      // Packet lock on ch1 (started in static mode), mode/sel toggled mid-packet
      mode     = 1'b0;
      sel      = 2'd1;
      in_valid = 4'b0111;
      in_last  = 4'b0000;
      in_data  = {8'h00, 8'hB2, 8'hC1, 8'hB0};
      @(negedge clk);
      chk("lock_beat1_ready", {60'd0, in_ready}, 64'h2);
      push(8'hC1, 1'b0, 2'd1);
      tick();
      mode    = 1'b1;
      sel     = 2'd0;
      in_data = {8'h00, 8'hB2, 8'hC2, 8'hB0};
      @(negedge clk);
      chk("lock_beat2_ready", {60'd0, in_ready}, 64'h2);
      push(8'hC2, 1'b0, 2'd1);
      tick();
      in_data = {8'h00, 8'hB2, 8'hC3, 8'hB0};
      in_last = 4'b0111;
      @(negedge clk);
      chk("lock_beat3_ready", {60'd0, in_ready}, 64'h2);
      push(8'hC3, 1'b1, 2'd1);
      tick();
      @(negedge clk);
      chk("after_lock_ready", {60'd0, in_ready}, 64'h4);
      push(8'hB2, 1'b1, 2'd2);
      tick();
      in_valid = 4'b0000;
      tick();

      // Backpressure on ch3
      in_valid  = 4'b1000;
      in_last   = 4'b1000;
      in_data   = {8'hD0, 24'h0};
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_first_ready", {60'd0, in_ready}, 64'h8);
      push(8'hD0, 1'b1, 2'd3);
      tick();
      in_data = {8'hD1, 24'h0};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_ready_low", {60'd0, in_ready}, 64'h0);
         chk("bp_data_hold", {56'd0, out_data}, 64'hD0);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      push(8'hD1, 1'b1, 2'd3);
      tick();
      chk("no_bubble", {63'd0, out_valid}, 64'd1);
      in_data = {8'hD2, 24'h0};
      push(8'hD2, 1'b1, 2'd3);
      tick();
      chk("no_bubble", {63'd0, out_valid}, 64'd1);
      in_data = {8'hD3, 24'h0};
      push(8'hD3, 1'b1, 2'd3);
      tick();
      chk("no_bubble", {63'd0, out_valid}, 64'd1);
      in_valid = 4'b0000;
      tick();
      tick();

      // Move rr_ptr to 2, lock on ch2, then reset mid-packet
      in_valid = 4'b0010;
      in_last  = 4'b0010;
      in_data  = {8'h00, 8'h00, 8'hF1, 8'h00};
      push(8'hF1, 1'b1, 2'd1);
      tick();
      in_valid = 4'b0100;
      in_last  = 4'b0000;
      in_data  = {8'h00, 8'hE0, 8'hF1, 8'h00};
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("lock_held_data", {56'd0, out_data}, 64'hE0);
      chk("lock_held_ready", {60'd0, in_ready}, 64'h0);
      tick();
      rst_n = 1'b0;
      tick();
      chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_in_ready", {60'd0, in_ready}, 64'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 4'b1111;
      in_last   = 4'b1111;
      in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      @(negedge clk);
      chk("post_rst_grant", {60'd0, in_ready}, 64'h1);
      push(8'hA0, 1'b1, 2'd0);
      tick();
      in_valid = 4'b0000;
      tick();
      tick();

      // Eight-channel instance: sel pointing at an idle channel grants nothing
      @(negedge clk);
      chk("sel5_no_grant", {56'd0, in_ready8}, 64'h0);
      chk("sel5_no_output", {63'd0, out_valid8}, 64'd0);
      tick();
      sel8 = 3'd3;
      @(negedge clk);
      chk("sel3_grant", {56'd0, in_ready8}, 64'h08);
      tick();
      chk("sel3_out", {52'd0, out_valid8, out_last8, out_ch8, out_data8}, {52'd0, 1'b1, 1'b1, 3'd3, 8'h33});

      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 streaming multiplexer: successor to the 1-bit 2:1 combinational mux.
- Selects one of NUM_CH valid/ready input channels of WIDTH bits and drives a single registered output stream.
- Two selection modes: static (external sel, as in the 2:1 mux) and round-robin with packet lock.
- Sits between multiple data producers and one shared downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (>=2).
- WIDTH, 8, data width per channel.
- CH_W, $clog2(NUM_CH), width of sel and out_ch (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  1  0 = static select via sel; 1 = round-robin.
- sel  in  CH_W  channel index used when mode=0.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel valid.
- in_last  in  NUM_CH  per-channel end-of-packet marker.
- in_ready  out  NUM_CH  per-channel ready (one-hot or zero).
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  output holds a beat.
- out_last  out  1  registered in_last of the accepted beat.
- out_ch  out  CH_W  source channel of the current output beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, state=IDLE. in_ready=0 while rst_n=0. Reset mid-packet discards the lock and any held beat.
- Output stage: single register. can_load = ~out_valid | out_ready. Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat/cycle under continuous out_ready.
- Handshakes: an input beat transfers when in_valid[i] & in_ready[i]. Output transfers when out_valid & out_ready. out_data, out_last and out_ch stay stable while out_valid & ~out_ready.
- in_ready[i] = grant[i] & can_load. grant is one-hot or zero and purely combinational from state, mode, sel, in_valid and rr_ptr.
- FSM states:
  - IDLE:
    - mode=0: grant = sel if in_valid[sel]. If sel >= NUM_CH, no grant.
    - mode=1: grant the first valid channel searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
    - On an accepted beat with in_last=0: go to LOCKED and record lock_ch = granted channel.
    - On an accepted beat with in_last=1: stay in IDLE.
  - LOCKED: grant = lock_ch only, regardless of mode, sel or other valids. Return to IDLE when a beat with in_last=1 is accepted from lock_ch.
- rr_ptr update: on each accepted beat with in_last=1 in mode=1, rr_ptr = granted channel + 1, wrapping NUM_CH-1 to 0. rr_ptr is unchanged in mode=0.
- Changes to mode or sel take effect only in IDLE. While LOCKED they are ignored.
- If no in_valid is set in IDLE: no grant and out_valid clears after the held beat is consumed.
- Simultaneous output drain and input load in the same cycle: new beat replaces the old one, out_valid stays 1, no bubble.

Decomposition:
- Package stream_mux_pkg:
  - state enum {IDLE, LOCKED}.
  - MODE_STATIC=1'b0 and MODE_RR=1'b1 constants.
- Sub-module rr_arbiter (NUM_CH parameter):
  - Inputs: req[NUM_CH], ptr[CH_W].
  - Output: one-hot gnt.
  - Purely combinational rotate-priority-rotate-back logic.
- The top level holds the FSM, rr_ptr, lock_ch, output register and the static-select path.

Test Plan:
- Reset: rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, in_ready=0000, out_ch=0. First grant after release goes to ch0 (mode=1).
- Static mode: mode=0, sel=2, in_valid=1111, ch2 data 0xA5, last=1, out_ready=1 -> in_ready=0100. Next cycle out_data=0xA5, out_ch=2. sel=5 with NUM_CH=8 and only ch0-3 valid -> no grant.
- Round-robin fairness: mode=1, all channels valid, single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0,1.
- Packet lock: ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 stay valid -> out_ch=1 for 3 consecutive beats, then 2. Toggling sel/mode mid-packet has no effect.
- Backpressure: out_ready=0 for 4 cycles with ch3 valid -> out_data stable, in_ready=0 after the first load. Releasing out_ready gives back-to-back beats with no bubble.
- Reset mid-packet: assert rst_n=0 while LOCKED on ch2 -> state=IDLE, out_valid=0. Next arbitration starts at rr_ptr=0.
